mnacidpro_ctl_seq: RTL and testbench

MNACIDPRO_CTL_SEQ -- requirements
Module: mnacidpro_ctl_seq

---
 rtl/mnacidpro_ctl_seq.sv | 204 ++++++++++++++++++++
 tb/tb_mnacidpro_ctl_seq.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/mnacidpro_ctl_seq.sv
// Nucleic-acid prep valve/pump sequencer: LYSIS -> TRAP -> WASH -> ELUTE -> DONE.
// Optional macro MNACIDPRO_WASH_REPEAT_EN repeats WASH for WASH_REPS passes.
module mnacidpro_ctl_seq #(
    parameter int unsigned PUMP_DIV  = 4,
    parameter int unsigned T_LYSIS   = 12,
    parameter int unsigned T_TRAP    = 12,
    parameter int unsigned T_WASH    = 12,
    parameter int unsigned T_ELUTE   = 12,
    parameter int unsigned WASH_REPS = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       abort,
    output logic       lysis_ctl,
    output logic       wash_ctl,
    output logic       elute_ctl,
    output logic       horiz_ctl,
    output logic       vertical_ctl,
    output logic       dead_end_ctl,
    output logic       loop_exit_ctl,
    output logic       bead_vtl_ctl,
    output logic       bead_trap_ctl,
    output logic       collection_ctl,
    output logic       pump1,
    output logic       pump2,
    output logic       pump3,
    output logic       busy,
    output logic       done,
    output logic [2:0] phase
);

    localparam int unsigned TW  = 16;
    localparam int unsigned DW  = 8;
    localparam int unsigned NVL = 10;

    localparam logic [TW-1:0] LEN_LYSIS = TW'(T_LYSIS * PUMP_DIV);
    localparam logic [TW-1:0] LEN_TRAP  = TW'(T_TRAP * PUMP_DIV);
    localparam logic [TW-1:0] LEN_WASH  = TW'(T_WASH * PUMP_DIV);
    localparam logic [TW-1:0] LEN_ELUTE = TW'(T_ELUTE * PUMP_DIV);
    localparam logic [DW-1:0] DIV_LAST  = DW'(PUMP_DIV - 1);

    // Elaboration-time parameter range guards
    if (PUMP_DIV < 1 || PUMP_DIV > 255) begin : g_bad_div
        $error("PUMP_DIV out of range");
    end
    if (WASH_REPS < 1 || WASH_REPS > 15) begin : g_bad_reps
        $error("WASH_REPS out of range");
    end

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LYSIS = 3'd1,
        ST_TRAP  = 3'd2,
        ST_WASH  = 3'd3,
        ST_ELUTE = 3'd4,
        ST_DONE  = 3'd5
    } state_e;

    state_e             state_q, state_d;
    logic [TW-1:0]      timer_q, timer_d;
    logic [DW-1:0]      pdiv_q, pdiv_d;
    logic [2:0]         step_q, step_d;
    logic [NVL-1:0]     valve_q, valve_d;
    logic [2:0]         pump_q, pump_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [2:0]         phase_q, phase_d;
    logic [TW-1:0]      len_cur;
    logic               phase_end;
    logic               wash_again;
    logic               reload;
`ifdef MNACIDPRO_WASH_REPEAT_EN
    logic [3:0]         rep_q, rep_d;
`endif

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic; abort overrides every other transition
    always_comb begin
        state_d    = state_q;
        wash_again = 1'b0;
        case (state_q)
            ST_LYSIS: len_cur = LEN_LYSIS;
            ST_TRAP:  len_cur = LEN_TRAP;
            ST_WASH:  len_cur = LEN_WASH;
            ST_ELUTE: len_cur = LEN_ELUTE;
            default:  len_cur = TW'(1);
        endcase
        phase_end = (timer_q >= len_cur - TW'(1));
        case (state_q)
            ST_IDLE:  if (start) state_d = ST_LYSIS;
            ST_LYSIS: if (phase_end) state_d = ST_TRAP;
            ST_TRAP:  if (phase_end) state_d = ST_WASH;
            ST_WASH: begin
                if (phase_end) begin
`ifdef MNACIDPRO_WASH_REPEAT_EN
                    if (rep_q != 4'(WASH_REPS - 1)) wash_again = 1'b1;
                    else                            state_d    = ST_ELUTE;
`else
                    state_d = ST_ELUTE;
`endif
                end
            end
            ST_ELUTE: if (phase_end) state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
        if (abort) begin
            state_d    = ST_IDLE;
            wash_again = 1'b0;
        end
    end

    // Phase timer, pump prescaler and step; all restart on any state entry or wash pass
    always_comb begin
        reload  = (state_d != state_q) || wash_again || abort;
        timer_d = (timer_q == '1) ? timer_q : timer_q + TW'(1);
        pdiv_d  = (pdiv_q == DIV_LAST) ? '0 : pdiv_q + DW'(1);
        step_d  = step_q;
        if (pdiv_q == DIV_LAST) step_d = (step_q == 3'd5) ? 3'd0 : step_q + 3'd1;
        if (reload || state_d == ST_IDLE || state_d == ST_DONE) begin
            timer_d = '0;
            pdiv_d  = '0;
            step_d  = '0;
        end
    end

`ifdef MNACIDPRO_WASH_REPEAT_EN
    always_comb begin
        rep_d = rep_q;
        if (state_d != ST_WASH) rep_d = '0;
        else if (wash_again)    rep_d = rep_q + 4'd1;
    end
`endif

    // Registered outputs reflect the state being entered
    always_comb begin
        valve_d = '1;
        pump_d  = 3'b000;
        busy_d  = (state_d != ST_IDLE);
        done_d  = (state_d == ST_DONE);
        phase_d = state_d;
        // bit order: lysis wash elute horiz vertical dead_end loop_exit bead_vtl bead_trap collection
        case (state_d)
            ST_LYSIS: valve_d = 10'b0110111111;
            ST_TRAP:  valve_d = 10'b1111010111;
            ST_WASH:  valve_d = 10'b1011100111;
            ST_ELUTE: valve_d = 10'b1101111000;
            default:  valve_d = '1;
        endcase
        if (state_d inside {ST_LYSIS, ST_TRAP, ST_WASH, ST_ELUTE}) begin
            case (step_d)
                3'd0:    pump_d = 3'b100;
                3'd1:    pump_d = 3'b110;
                3'd2:    pump_d = 3'b010;
                3'd3:    pump_d = 3'b011;
                3'd4:    pump_d = 3'b001;
                default: pump_d = 3'b101;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timer_q <= '0;
            pdiv_q  <= '0;
            step_q  <= '0;
            valve_q <= '1;
            pump_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            phase_q <= '0;
        end else begin
            timer_q <= timer_d;
            pdiv_q  <= pdiv_d;
            step_q  <= step_d;
            valve_q <= valve_d;
            pump_q  <= pump_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            phase_q <= phase_d;
        end
    end

`ifdef MNACIDPRO_WASH_REPEAT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) rep_q <= '0;
        else     rep_q <= rep_d;
    end
`endif

    assign {lysis_ctl, wash_ctl, elute_ctl, horiz_ctl, vertical_ctl, dead_end_ctl,
            loop_exit_ctl, bead_vtl_ctl, bead_trap_ctl, collection_ctl} = valve_q;
    assign {pump1, pump2, pump3} = pump_q;
    assign busy  = busy_q;
    assign done  = done_q;
    assign phase = phase_q;

endmodule

// File: tb/tb_mnacidpro_ctl_seq.sv
// Directed bench for mnacidpro_ctl_seq with PUMP_DIV=2, all phases 3 steps, WASH_REPS=2.
module tb_mnacidpro_ctl_seq;

    logic clk = 1'b0;
    logic rst, start, abort;
    logic lysis_ctl, wash_ctl, elute_ctl, horiz_ctl, vertical_ctl, dead_end_ctl;
    logic loop_exit_ctl, bead_vtl_ctl, bead_trap_ctl, collection_ctl;
    logic pump1, pump2, pump3, busy, done;
    logic [2:0] phase;
    int checks = 0;
    int errors = 0;

`ifdef MNACIDPRO_WASH_REPEAT_EN
    localparam int WL = 12;
`else
    localparam int WL = 6;
`endif
    localparam int DONE_C = 19 + WL;

    mnacidpro_ctl_seq #(
        .PUMP_DIV(2), .T_LYSIS(3), .T_TRAP(3), .T_WASH(3), .T_ELUTE(3), .WASH_REPS(2)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .lysis_ctl(lysis_ctl), .wash_ctl(wash_ctl), .elute_ctl(elute_ctl),
        .horiz_ctl(horiz_ctl), .vertical_ctl(vertical_ctl), .dead_end_ctl(dead_end_ctl),
        .loop_exit_ctl(loop_exit_ctl), .bead_vtl_ctl(bead_vtl_ctl),
        .bead_trap_ctl(bead_trap_ctl), .collection_ctl(collection_ctl),
        .pump1(pump1), .pump2(pump2), .pump3(pump3),
        .busy(busy), .done(done), .phase(phase)
    );

    always #5 clk = ~clk;

    function automatic logic [9:0] valves();
        return {lysis_ctl, wash_ctl, elute_ctl, horiz_ctl, vertical_ctl, dead_end_ctl,
                loop_exit_ctl, bead_vtl_ctl, bead_trap_ctl, collection_ctl};
    endfunction

    function automatic int exp_phase(input int c);
        if (c < 1)            return 0;
        if (c <= 6)           return 1;
        if (c <= 12)          return 2;
        if (c <= 12 + WL)     return 3;
        if (c <= 18 + WL)     return 4;
        if (c == DONE_C)      return 5;
        return 0;
    endfunction

    function automatic logic [9:0] exp_valve(input int ph);
        case (ph)
            1:       return 10'b0110111111;
            2:       return 10'b1111010111;
            3:       return 10'b1011100111;
            4:       return 10'b1101111000;
            default: return 10'b1111111111;
        endcase
    endfunction

    function automatic logic [2:0] exp_pump(input int c);
        logic [2:0] pat [6];
        int ph, s;
        pat = '{3'b100, 3'b110, 3'b010, 3'b011, 3'b001, 3'b101};
        ph = exp_phase(c);
        case (ph)
            1:       s = 1;
            2:       s = 7;
            3:       s = 13;
            4:       s = 13 + WL;
            default: return 3'b000;
        endcase
        return pat[((c - s) % 6) / 2];
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, " phase"}, 32'(phase), 32'd0);
        check({tag, " valves"}, 32'(valves()), 32'h3FF);
        check({tag, " pumps"}, 32'({pump1, pump2, pump3}), 32'd0);
        check({tag, " busy"}, 32'(busy), 32'd0);
        check({tag, " done"}, 32'(done), 32'd0);
    endtask

    // Start (pulse or held) sampled at the next edge; checks every cycle for ncyc cycles
    task automatic run_seq(input string tag, input int ncyc, input bit hold);
        int cc;
        start = 1'b1;
        for (int c = 1; c <= ncyc; c++) begin
            tick();
            if (!hold) start = 1'b0;
            cc = (hold && c > DONE_C + 1) ? c - (DONE_C + 1) : c;
            check($sformatf("%s phase c%0d", tag, c), 32'(phase), 32'(exp_phase(cc)));
            check($sformatf("%s done c%0d", tag, c), 32'(done), 32'(exp_phase(cc) == 5));
            check($sformatf("%s busy c%0d", tag, c), 32'(busy), 32'(exp_phase(cc) != 0));
            check($sformatf("%s valves c%0d", tag, c), 32'(valves()), 32'(exp_valve(exp_phase(cc))));
            check($sformatf("%s pumps c%0d", tag, c), 32'({pump1, pump2, pump3}), 32'(exp_pump(cc)));
        end
        start = 1'b0;
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; abort = 1'b0;
        #1 rst = 1'b1;
        #1 check_reset_vals("reset");
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b0;

        // Basic run with start honored on the first edge after reset release
        run_seq("basic", DONE_C + 2, 1'b0);

        // Abort and start together in IDLE: abort wins
        start = 1'b1; abort = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0;
        check("abort_idle phase", 32'(phase), 32'd0);
        check("abort_idle busy", 32'(busy), 32'd0);
        tick();

        // Abort during ELUTE at cycle 20
        start = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            tick();
            start = 1'b0;
            check($sformatf("abort done c%0d", c), 32'(done), 32'd0);
        end
        check("abort pre phase", 32'(phase), 32'd4);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check_reset_vals("abort c21");
        for (int c = 22; c <= 30; c++) begin
            tick();
            check($sformatf("abort idle done c%0d", c), 32'(done), 32'd0);
            check($sformatf("abort idle phase c%0d", c), 32'(phase), 32'd0);
        end

        // Asynchronous reset in the middle of WASH
        start = 1'b1;
        for (int c = 1; c <= 15; c++) begin
            tick();
            start = 1'b0;
        end
        check("midrst pre phase", 32'(phase), 32'd3);
        #2 rst = 1'b1;
        #1 check_reset_vals("midrst async");
        @(negedge clk) rst = 1'b0;
        run_seq("after_rst", DONE_C + 2, 1'b0);

        // Start held high: no mid-run restart, new run from the IDLE cycle after DONE
        run_seq("held", DONE_C + 4, 1'b1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check_reset_vals("held abort");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
